piano_core: RTL

PIANO_CORE -- requirements
Module: piano_core

---
 rtl/piano_pkg.sv | 53 +++++
 rtl/key_debounce.sv | 63 ++++++
 rtl/piano_core.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// -----------------------------------------------------------------------------
// piano_pkg
//   Shared definitions for the piano tone generator:
//     - piano_state_e : FSM state encoding (IDLE / PLAY / SUSTAIN)
//     - NOTE_MHZ      : octave-4 chromatic note table in millihertz (C4 .. B4)
//     - OCT_*         : encoding of the 2-bit octave select input
//     - half_period() : elaboration-time helper turning a note index into the
//                       octave-4 half period in clock cycles
// -----------------------------------------------------------------------------
package piano_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_SUSTAIN = 2'd2
  } piano_state_e;

  localparam int NUM_NOTES = 12;

  // Octave-4 equal-tempered frequencies, millihertz. Index 0 = C4, 9 = A4.
  localparam int unsigned NOTE_MHZ [NUM_NOTES] = '{
    32'd261626,  // C4
    32'd277183,  // C#4
    32'd293665,  // D4
    32'd311127,  // D#4
    32'd329628,  // E4
    32'd349228,  // F4
    32'd369994,  // F#4
    32'd391995,  // G4
    32'd415305,  // G#4
    32'd440000,  // A4
    32'd466164,  // A#4
    32'd493883   // B4
  };

  // Octave select encoding; OCT_4 plays the table as-is.
  localparam logic [1:0] OCT_3 = 2'd0;
  localparam logic [1:0] OCT_4 = 2'd1;
  localparam logic [1:0] OCT_5 = 2'd2;
  localparam logic [1:0] OCT_6 = 2'd3;

  // Octave-4 half period in clock cycles, truncated. Only ever called with
  // constant arguments, so it folds away during elaboration. Indices outside
  // the table return 0.
  function automatic longint unsigned half_period(input longint unsigned clk_hz,
                                                  input int              idx);
    longint unsigned mhz;
    if (idx < 0 || idx >= NUM_NOTES) return 64'd0;
    mhz = 64'(NOTE_MHZ[idx[3:0]]);
    return (clk_hz * 64'd1000) / (64'd2 * mhz);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   One key channel: 2-flop synchroniser followed by a counting debouncer.
//   The debounced level flips on the edge where the synchronised input has
//   disagreed with it for DEBOUNCE_CYC consecutive edges; any agreeing sample
//   clears the run count.
//
//   Ports
//     clk      : system clock, rising edge
//     rst      : synchronous active-high reset (clears sync flops, count, level)
//     key_raw  : raw asynchronous switch, 1 = pressed
//     key_deb  : debounced, registered key level
// -----------------------------------------------------------------------------
module key_debounce
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_deb
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q,   deb_d;
  logic [DW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      // This sample completes the run: flip now and start a fresh count.
      if (cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_deb = deb_q;

endmodule

// File: rtl/piano_core.sv
// -----------------------------------------------------------------------------
// piano_core
//   Chromatic key-to-tone generator. Each key is synchronised and debounced,
//   the highest pressed key selects the note, and a half-period counter
//   produces a 50% duty square wave for the latched note and octave.
//
//   Ports
//     clk        : sole clock, rising edge
//     rst        : synchronous active-high reset, overrides everything
//     keys       : raw key switches [NUM_KEYS], 1 = pressed, key i = note i
//     octave     : 0..3 selects octave 3..6, sampled only when a note latches
//     sustain_en : hold the last note for SUSTAIN_CYC cycles after release
//     speaker    : square-wave tone output
//     led        : debounced key levels
//     note_valid : high while a tone is sounding (PLAY or SUSTAIN)
//     note_idx   : sounding note index, 0 when idle
// -----------------------------------------------------------------------------
module piano_core
  import piano_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int NUM_KEYS     = 12,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SUSTAIN_CYC  = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [1:0]          octave,
  input  logic                sustain_en,
  output logic                speaker,
  output logic [NUM_KEYS-1:0] led,
  output logic                note_valid,
  output logic [3:0]          note_idx
);

  // C4 at octave 3 is the longest half period; the counter is sized for it.
  localparam longint unsigned HP_MAX = half_period(64'(CLK_HZ), 0) << 1;
  localparam int CW = (HP_MAX > 1) ? $clog2(HP_MAX + 1) : 1;
  localparam int SW = (SUSTAIN_CYC > 1) ? $clog2(SUSTAIN_CYC + 1) : 1;

  // ---------------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] deb;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
      .clk     (clk),
      .rst     (rst),
      .key_raw (keys[k]),
      .key_deb (deb[k])
    );
  end

  // Highest-index pressed key wins; later iterations overwrite earlier ones.
  logic       any_key;
  logic [3:0] sel;

  always_comb begin
    any_key = 1'b0;
    sel     = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (deb[i]) begin
        any_key = 1'b1;
        sel     = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Half-period lookup: constant octave-4 table, shifted by the latched octave
  // ---------------------------------------------------------------------------
  logic [CW-1:0] hp_tab [16];

  for (genvar g = 0; g < 16; g++) begin : g_hp
    localparam longint unsigned HPV = half_period(64'(CLK_HZ), g);
    assign hp_tab[g] = HPV[CW-1:0];
  end

  logic [3:0]    note_q, note_d;
  logic [1:0]    oct_q,  oct_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          spk_q,  spk_d;
  logic [SW-1:0] sus_q,  sus_d;
  logic [CW-1:0] hp_base;
  logic [CW-1:0] hp_cur;

  always_comb begin
    hp_base = hp_tab[note_q];
    case (oct_q)
      OCT_3:   hp_cur = hp_base << 1;
      OCT_4:   hp_cur = hp_base;
      OCT_5:   hp_cur = hp_base >> 1;
      default: hp_cur = hp_base >> 2;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  piano_state_e state_q, state_d;
  logic         sus_done;

  assign sus_done = (sus_q == SW'(SUSTAIN_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_key) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (!any_key) state_d = sustain_en ? ST_SUSTAIN : ST_IDLE;
      end
      ST_SUSTAIN: begin
        // Disabling sustain beats a new press, which beats the hold timer.
        if (!sustain_en)    state_d = ST_IDLE;
        else if (any_key)   state_d = ST_PLAY;
        else if (sus_done)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    note_valid = (state_q != ST_IDLE);
    note_idx   = note_valid ? note_q : 4'd0;
    speaker    = spk_q;
    led        = deb;
  end

  // ---------------------------------------------------------------------------
  // Tone datapath
  // ---------------------------------------------------------------------------
  logic latch;

  // A note latches when PLAY is entered or when the selection changes in PLAY.
  assign latch = (state_d == ST_PLAY) &&
                 ((state_q != ST_PLAY) || (sel != note_q));

  always_comb begin
    note_d = note_q;
    oct_d  = oct_q;
    cnt_d  = cnt_q;
    spk_d  = spk_q;
    sus_d  = sus_q;
    if (state_d == ST_IDLE) begin
      note_d = '0;
      cnt_d  = '0;
      spk_d  = 1'b0;
      sus_d  = '0;
    end else if (latch) begin
      // New note restarts its period but keeps the current speaker level.
      note_d = sel;
      oct_d  = octave;
      cnt_d  = '0;
      sus_d  = '0;
    end else begin
      if (cnt_q == hp_cur - CW'(1)) begin
        cnt_d = '0;
        spk_d = ~spk_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (state_d == ST_SUSTAIN) begin
        sus_d = (state_q == ST_SUSTAIN) ? sus_q + SW'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_q <= '0;
      oct_q  <= '0;
      cnt_q  <= '0;
      spk_q  <= 1'b0;
      sus_q  <= '0;
    end else begin
      note_q <= note_d;
      oct_q  <= oct_d;
      cnt_q  <= cnt_d;
      spk_q  <= spk_d;
      sus_q  <= sus_d;
    end
  end

endmodule
